// File: rtl/maze_gen_ctrl.sv
// maze_gen_ctrl: run sequencer for a single mazegen instance.
// Owns that instance's seed and reset, waits for generation with a timeout,
// then snapshots the finished maze and streams it out one row per handshake.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; all run outputs quiet
// S_RESET  | gen_rst held high for RST_CYCLES cycles, seed already latched
// S_GEN    | counting cycles, waiting for gen_done or timeout
// S_STREAM | presenting snapshot rows on the valid/ready interface
module maze_gen_ctrl #(
    parameter int SIZE       = 8,
    parameter int N          = $clog2(SIZE),
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 20000,
    parameter int CW         = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [15:0]            seed_in,
    output logic                   gen_rst,
    output logic [15:0]            gen_seed,
    input  logic                   gen_done,
    input  logic [SIZE*SIZE-1:0]   gen_maze,
    output logic [SIZE-1:0]        row_data,
    output logic [N-1:0]           row_idx,
    output logic                   row_valid,
    input  logic                   row_ready,
    output logic                   row_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [CW-1:0]          gen_cycles
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RESET  = 2'd1,
        S_GEN    = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    localparam int             RW       = $clog2(RST_CYCLES + 1);
    localparam logic [RW-1:0]  RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]  TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [N-1:0]   IDX_LAST = N'(SIZE - 1);

    state_t                 state_q, state_d;
    logic [RW-1:0]          rcnt_q, rcnt_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SIZE*SIZE-1:0]   snap_q, snap_d;
    logic [15:0]            seed_q, seed_d;
    logic                   gen_rst_q, gen_rst_d;
    logic [SIZE-1:0]        row_data_q, row_data_d;
    logic [N-1:0]           row_idx_q, row_idx_d;
    logic                   row_valid_q, row_valid_d;
    logic                   row_last_q, row_last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [CW-1:0]          gcyc_q, gcyc_d;
    logic [N-1:0]           nxt_idx;

    // Next-state and registered-output decisions; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        cnt_d       = cnt_q;
        snap_d      = snap_q;
        seed_d      = seed_q;
        gen_rst_d   = gen_rst_q;
        row_data_d  = row_data_q;
        row_idx_d   = row_idx_q;
        row_valid_d = row_valid_q;
        row_last_d  = row_last_q;
        gcyc_d      = gcyc_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        nxt_idx     = row_idx_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d   = S_RESET;
                    seed_d    = seed_in;
                    gen_rst_d = 1'b1;
                    rcnt_d    = RST_LAST;
                end
            end
            S_RESET: begin
                if (rcnt_q == '0) begin
                    state_d   = S_GEN;
                    gen_rst_d = 1'b0;
                    cnt_d     = '0;
                end else begin
                    rcnt_d = rcnt_q - 1'b1;
                end
            end
            S_GEN: begin
                // cnt_q == 0 is the first GEN cycle; a done seen there may
                // predate the reset, so it is not trusted.
                if (gen_done && (cnt_q != '0)) begin
                    state_d     = S_STREAM;
                    snap_d      = gen_maze;
                    gcyc_d      = cnt_q;
                    row_valid_d = 1'b1;
                    row_idx_d   = '0;
                    row_data_d  = gen_maze[SIZE-1:0];
                    row_last_d  = (SIZE == 1);
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STREAM: begin
                if (row_valid_q && row_ready) begin
                    if (row_last_q) begin
                        state_d     = S_IDLE;
                        row_valid_d = 1'b0;
                        row_last_d  = 1'b0;
                        row_idx_d   = '0;
                        row_data_d  = '0;
                        done_d      = 1'b1;
                    end else begin
                        row_idx_d  = nxt_idx;
                        row_data_d = snap_q[int'(nxt_idx)*SIZE +: SIZE];
                        row_last_d = (nxt_idx == IDX_LAST);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            gen_rst_d   = 1'b0;
            row_valid_d = 1'b0;
            row_last_d  = 1'b0;
            row_idx_d   = '0;
            row_data_d  = '0;
            done_d      = 1'b0;
            err_d       = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rcnt_q      <= '0;
            cnt_q       <= '0;
            snap_q      <= '0;
            seed_q      <= '0;
            gen_rst_q   <= 1'b0;
            row_data_q  <= '0;
            row_idx_q   <= '0;
            row_valid_q <= 1'b0;
            row_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            gcyc_q      <= '0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            seed_q      <= seed_d;
            gen_rst_q   <= gen_rst_d;
            row_data_q  <= row_data_d;
            row_idx_q   <= row_idx_d;
            row_valid_q <= row_valid_d;
            row_last_q  <= row_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            gcyc_q      <= gcyc_d;
        end
    end

    assign gen_rst    = gen_rst_q;
    assign gen_seed   = seed_q;
    assign row_data   = row_data_q;
    assign row_idx    = row_idx_q;
    assign row_valid  = row_valid_q;
    assign row_last   = row_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign gen_cycles = gcyc_q;

endmodule

// File: tb/tb_maze_gen_ctrl.sv
// Directed bench for maze_gen_ctrl with SIZE=8 and a short timeout.
module tb_maze_gen_ctrl;

    localparam int SIZE = 8;
    localparam int N    = 3;
    localparam int CW   = 16;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic [15:0]          seed_in;
    logic                 gen_rst;
    logic [15:0]          gen_seed;
    logic                 gen_done;
    logic [SIZE*SIZE-1:0] gen_maze;
    logic [SIZE-1:0]      row_data;
    logic [N-1:0]         row_idx;
    logic                 row_valid;
    logic                 row_ready;
    logic                 row_last;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [CW-1:0]        gen_cycles;

    int total = 0;
    int bad   = 0;
    int xf, cyc, dn, seen;

    logic [63:0] maze_a, maze_b, maze_c;

    maze_gen_ctrl #(
        .SIZE(SIZE), .N(N), .RST_CYCLES(2), .TIMEOUT(100), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seed_in(seed_in),
        .gen_rst(gen_rst), .gen_seed(gen_seed), .gen_done(gen_done),
        .gen_maze(gen_maze), .row_data(row_data), .row_idx(row_idx),
        .row_valid(row_valid), .row_ready(row_ready), .row_last(row_last),
        .busy(busy), .done(done), .err(err), .gen_cycles(gen_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] row_of(input logic [63:0] m, input int y);
        return m[y*8 +: 8];
    endfunction

    // Start a run and step through RESET; returns in the first GEN cycle.
    task automatic launch(input logic [15:0] s);
        seed_in = s;
        start   = 1'b1;
        tick;
        start   = 1'b0;
        chk("rst_hi1", gen_rst, 1);
        chk("busy_rise", busy, 1);
        chk("seed", gen_seed, s);
        tick;
        chk("rst_hi2", gen_rst, 1);
        tick;
        chk("rst_lo", gen_rst, 0);
        chk("seed_hold", gen_seed, s);
    endtask

    // gen_done is sampled at the edge where the GEN counter equals k.
    task automatic gen_for(input int k);
        repeat (k) tick;
        gen_done = 1'b1;
        tick;
        gen_done = 1'b0;
        chk("cap_valid", row_valid, 1);
        chk("gen_cycles", gen_cycles, k);
    endtask

    task automatic drain(input logic [63:0] m);
        row_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("row_valid", row_valid, 1);
            chk("row_idx", row_idx, i);
            chk("row_data", row_data, row_of(m, i));
            chk("row_last", row_last, (i == 7));
            tick;
        end
        chk("done_pulse", done, 1);
        chk("valid_off", row_valid, 0);
        chk("busy_off", busy, 0);
        tick;
        chk("done_once", done, 0);
    endtask

    initial begin
        maze_a    = 64'h0123_4567_89AB_CDEF;
        maze_b    = 64'hF00D_BEEF_1357_9BDF;
        maze_c    = 64'hFFFF_FFFF_FFFF_FFFF;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        seed_in   = 16'h0;
        gen_done  = 1'b0;
        gen_maze  = maze_a;
        row_ready = 1'b0;
        #2 rst = 1'b0;
        #8;
        chk("rs_busy", busy, 0);
        chk("rs_gen_rst", gen_rst, 0);
        chk("rs_seed", gen_seed, 0);
        chk("rs_valid", row_valid, 0);
        chk("rs_idx", row_idx, 0);
        chk("rs_data", row_data, 0);
        chk("rs_done_err", {done, err, row_last}, 0);
        chk("rs_gcyc", gen_cycles, 0);
        #2 rst = 1'b1;
        tick;

        // basic run
        launch(16'h00A5);
        gen_for(40);
        drain(maze_a);
        chk("basic_seed", gen_seed, 16'h00A5);

        // backpressure, maze change during stream, start while busy
        gen_maze = maze_b;
        launch(16'h1234);
        gen_for(5);
        gen_maze = maze_c;
        xf  = 0;
        cyc = 0;
        dn  = 0;
        while (xf < 8 && cyc < 60) begin
            row_ready = (cyc % 3 == 0);
            start     = (cyc == 4);
            seed_in   = 16'hFFFF;
            chk("bp_valid", row_valid, 1);
            chk("bp_idx", row_idx, xf);
            chk("bp_data", row_data, row_of(maze_b, xf));
            chk("bp_last", row_last, (xf == 7));
            if (row_ready) xf++;
            tick;
            cyc++;
            if (done) dn++;
        end
        start     = 1'b0;
        row_ready = 1'b0;
        chk("bp_xfers", xf, 8);
        repeat (5) begin
            tick;
            if (done) dn++;
        end
        chk("bp_done_count", dn, 1);
        chk("bp_idle", busy, 0);
        chk("bp_seed", gen_seed, 16'h1234);

        // timeout
        gen_maze = maze_a;
        launch(16'h0BAD);
        seen = 0;
        repeat (99) begin
            tick;
            if (row_valid || err) seen++;
        end
        chk("to_early", seen, 0);
        chk("to_busy_pre", busy, 1);
        tick;
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_valid", row_valid, 0);
        chk("to_gcyc", gen_cycles, 5);
        tick;
        chk("to_err_pulse", err, 0);

        // stale done held across start
        gen_done = 1'b1;
        launch(16'h5A5A);
        chk("stale_rst", row_valid, 0);
        tick;
        chk("stale_gen1", row_valid, 0);
        tick;
        gen_done = 1'b0;
        chk("stale_cap", row_valid, 1);
        chk("stale_gcyc", gen_cycles, 1);
        drain(maze_a);

        // abort at row 3
        launch(16'h0001);
        gen_for(3);
        row_ready = 1'b1;
        repeat (3) tick;
        chk("ab_idx3", row_idx, 3);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        row_ready = 1'b0;
        chk("ab_valid", row_valid, 0);
        chk("ab_idx", row_idx, 0);
        chk("ab_data", row_data, 0);
        chk("ab_busy", busy, 0);
        chk("ab_pulses", {done, err, gen_rst, row_last}, 0);
        tick;
        chk("ab_no_done", {done, err}, 0);

        // abort and start together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk("ab_start_busy", busy, 0);
        chk("ab_start_rst", gen_rst, 0);
        launch(16'h0002);
        gen_for(2);
        drain(maze_a);

        // reset mid-GEN
        launch(16'h0003);
        repeat (10) tick;
        rst = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_seed", gen_seed, 0);
        chk("mr_gcyc", gen_cycles, 0);
        chk("mr_outs", {row_valid, gen_rst, done, err}, 0);
        rst = 1'b1;
        tick;
        chk("mr_after", {busy, done, err}, 0);
        gen_maze = maze_b;
        launch(16'h0004);
        gen_for(7);
        drain(maze_b);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maze_gen_ctrl.md
Name: maze_gen_ctrl

Overview:
- Sequencer for one mazegen instance.
- On a start request it latches a seed, pulses mazegen's reset, and waits for generation to finish, with a timeout.
- It then snapshots the finished maze and streams it out one row per valid/ready handshake.
- It sits between the system-level control/readout logic and the mazegen datapath, and owns that instance's reset and seed.

Parameters:
- SIZE, 8, maze dimension (rows = columns = SIZE).
- N, $clog2(SIZE), row-index width.
- RST_CYCLES, 2, number of cycles gen_rst is held high per run (minimum 1).
- TIMEOUT, 20000, maximum GEN-state cycles before abandoning a run.
- CW, 16, width of the gen_cycles counter.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- rst, input, 1, asynchronous, active-low reset.
- start, input, 1, request a run; sampled only in IDLE.
- abort, input, 1, synchronous abort from any state.
- seed_in, input, 16, seed captured on an accepted start.
- gen_rst, output, 1, active-high synchronous reset to mazegen.
- gen_seed, output, 16, seed to mazegen; held stable for the whole run.
- gen_done, input, 1, mazegen completion flag.
- gen_maze, input, SIZE*SIZE, flattened maze; row y = bits [y*SIZE +: SIZE].
- row_data, output, SIZE, current row from the snapshot.
- row_idx, output, N, index of row_data.
- row_valid, output, 1, row_data/row_idx are valid.
- row_ready, input, 1, consumer accepts the row.
- row_last, output, 1, high with row_valid when row_idx == SIZE-1.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse after the last row transfers.
- err, output, 1, one-cycle pulse on timeout.
- gen_cycles, output, CW, GEN-state cycle count of the last completed run; saturates at all-ones.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; gen_rst = 0; gen_seed = 0.
  - row_valid = row_last = done = err = busy = 0; row_idx = 0; row_data = 0.
  - gen_cycles = 0; snapshot cleared.
  - Reset asserted mid-run aborts immediately, with no done or err pulse.
- States: IDLE, RESET, GEN, STREAM. All outputs are registered.
- IDLE:
  - start = 1 at edge t: gen_seed <= seed_in, move to RESET.
  - gen_rst is high in cycles t+1 .. t+RST_CYCLES; busy rises at t+1.
  - start asserted while busy is ignored; it is not queued.
- RESET:
  - Holds gen_rst for exactly RST_CYCLES cycles, then moves to GEN with gen_rst = 0.
  - gen_done is ignored in this state.
- GEN:
  - The internal counter clears on entry and increments each cycle.
  - gen_done is honoured from the 2nd GEN cycle onward, so a stale done before the reset takes effect is rejected.
  - On honoured gen_done: copy gen_maze into the snapshot, gen_cycles <= counter (saturated), move to STREAM.
  - First row_valid appears the cycle after the capture edge.
  - If the counter reaches TIMEOUT-1 without done: err pulses 1 cycle, move to IDLE, gen_cycles unchanged, no rows emitted.
- STREAM:
  - Starts with row_idx = 0 and row_valid = 1; row_data = snapshot row row_idx.
  - While row_valid && !row_ready: row_data, row_idx and row_last hold stable.
  - On row_valid && row_ready: row_idx increments; the next row is valid in the following cycle, so one row per cycle is possible with row_ready held high.
  - A transfer with row_last = 1 leads, next cycle, to row_valid = 0, done pulses 1 cycle, and state = IDLE.
  - The snapshot is immune to gen_maze changes during STREAM.
- abort:
  - Takes effect at the next edge from any non-IDLE state: state = IDLE, gen_rst = 0, row_valid = 0, row_idx = 0.
  - No done or err pulse. Abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: abort wins and the run does not start.
- Simultaneous events:
  - gen_done on the timeout cycle: done wins, and the run proceeds to STREAM.
  - done pulse and a new start in the same cycle: start is sampled in IDLE on the following cycle only.
- Width rules:
  - row_idx wraps only via return to IDLE; it never exceeds SIZE-1.
  - gen_cycles saturates at 2^CW-1.

Test Plan:
- Basic run:
  - Stimulus: SIZE = 8, seed_in = 16'h00A5, start pulse; model asserts gen_done 40 GEN cycles later; row_ready = 1.
  - Required: gen_rst high for 2 cycles; gen_seed = 00A5 throughout; 8 consecutive rows idx 0..7 match gen_maze; row_last only on idx 7; done 1 cycle after it; gen_cycles = 40.
- Backpressure:
  - Stimulus: row_ready toggles 1,0,0,1,...
  - Required: row_data/row_idx stable across stalls; exactly 8 transfers; gen_maze changed during STREAM does not alter the output.
- Timeout:
  - Stimulus: TIMEOUT = 100, gen_done never asserted.
  - Required: err pulse at GEN cycle 100; no row_valid; busy = 0 afterwards; gen_cycles keeps the prior value.
- Stale done:
  - Stimulus: gen_done held 1 across start.
  - Required: ignored in RESET and the 1st GEN cycle; capture occurs in the 2nd GEN cycle.
- Abort and reset:
  - Stimulus: abort at row_idx = 3; then a separate run with rst pulled low mid-GEN.
  - Required (both cases): outputs return to reset/IDLE values, no done/err pulse, and the next start runs normally.
- Start while busy:
  - Stimulus: start pulsed during STREAM.
  - Required: ignored; exactly one done pulse.
